// File: rtl/spi_mitm_pkg.sv
// spi_mitm_pkg: shared frame states, capture record layout and sample-edge selection
package spi_mitm_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int CAP_MISO_LSB = 0;
  function automatic int cap_mosi_lsb(input int data_size);
    return data_size;
  endfunction
  function automatic int cap_sub_bit(input int data_size);
    return 2 * data_size;
  endfunction
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return cpol == cpha;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a write while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_rd, do_wr;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = mem[rp[AW-1:0]];
  // pointer bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/spi_mitm_tap.sv
// spi_mitm_tap: SPI man-in-the-middle tap forwarding the bus, capturing words and substituting MISO
module spi_mitm_tap
  import spi_mitm_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int CPOL          = 0,
  parameter int CPHA          = 0,
  parameter int SS_ACTIVE_LOW = 0,
  parameter int CAP_DEPTH     = 4,
  parameter int SUB_DEPTH     = 4
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   miso_in,
  input  logic                   mosi_in,
  input  logic                   sclk_in,
  input  logic                   ss_in,
  output logic                   miso_out,
  output logic                   mosi_out,
  output logic                   sclk_out,
  output logic                   ss_out,
  input  logic                   sub_en,
  input  logic                   sub_wr_valid,
  output logic                   sub_wr_ready,
  input  logic [DATA_SIZE-1:0]   sub_wr_data,
  output logic                   cap_valid,
  input  logic                   cap_ready,
  output logic [2*DATA_SIZE:0]   cap_data,
  output logic                   cap_overflow,
  input  logic                   ovf_clr
);
  localparam int BW = $clog2(DATA_SIZE);
  localparam int RW = 2 * DATA_SIZE + 1;
  localparam int W1 = DATA_SIZE - 1;
  localparam logic SS_IDLE = SS_ACTIVE_LOW != 0;
  localparam logic SCLK_IDLE = CPOL != 0;
  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic MSB_AT_START = CPHA == 0;
  localparam logic [BW-1:0] LAST = BW'(DATA_SIZE - 1);

  logic [3:0] s1, s2;
  logic [1:0] fill;
  logic sclk_d, ss_act_d, armed;
  state_t state;
  logic [BW-1:0] bit_cnt, idx;
  logic [W1-1:0] mosi_sh, miso_sh;
  logic [DATA_SIZE-1:0] sub_sh, sub_rd_data;
  logic sub_act, pres;
  logic ss_act, sclk_rise, sclk_fall, sample, shift, active;
  logic entry, complete, start, sub_pop, miso_nx;
  logic cap_full, cap_empty, cap_drop, sub_full, sub_empty;
  logic [RW-1:0] cap_wr;

  assign ss_act    = s2[3] ^ SS_IDLE;
  assign sclk_rise = s2[2] & ~sclk_d;
  assign sclk_fall = ~s2[2] & sclk_d;
  assign sample    = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift     = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign active    = state == ACTIVE;
  assign entry     = ~active & armed & ss_act & ~ss_act_d;
  assign complete  = active & ss_act & sample & (bit_cnt == LAST);
  assign start     = entry | complete;
  assign sub_pop   = start & sub_en & ~sub_empty;
  assign idx       = LAST - bit_cnt;
  assign cap_drop  = complete & cap_full & ~cap_ready;
  assign cap_valid = ~cap_empty;
  assign sub_wr_ready = ~sub_full;

  // synchronisers, edge history, re-arm qualifier and forwarded outputs
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= {SS_IDLE, SCLK_IDLE, 2'b00};
      s2 <= {SS_IDLE, SCLK_IDLE, 2'b00};
      fill <= '0;
      sclk_d <= SCLK_IDLE;
      ss_act_d <= 1'b0;
      armed <= 1'b0;
      ss_out <= SS_IDLE;
      sclk_out <= SCLK_IDLE;
      mosi_out <= 1'b0;
    end else begin
      s1 <= {ss_in, sclk_in, mosi_in, miso_in};
      s2 <= s1;
      fill <= {fill[0], 1'b1};
      sclk_d <= s2[2];
      ss_act_d <= ss_act;
      armed <= armed | (fill[1] & ~ss_act);
      {ss_out, sclk_out, mosi_out} <= s2[3:1];
    end

  // miso output: word-start cycles hold so the last sampled bit is not disturbed
  always_comb begin
    miso_nx = miso_out;
    if (!start)
      miso_nx = !sub_act ? s2[0] :
                shift ? sub_sh[idx] :
                (pres & MSB_AT_START) ? sub_sh[DATA_SIZE-1] : miso_out;
  end

  // capture record assembly
  always_comb begin
    cap_wr = '0;
    cap_wr[CAP_MISO_LSB +: DATA_SIZE] = {miso_sh, s2[0]};
    cap_wr[cap_mosi_lsb(DATA_SIZE) +: DATA_SIZE] = {mosi_sh, s2[1]};
    cap_wr[cap_sub_bit(DATA_SIZE)] = sub_act;
  end

  // frame FSM with word shifting and substitution control
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      mosi_sh <= '0;
      miso_sh <= '0;
      sub_sh <= '0;
      sub_act <= 1'b0;
      pres <= 1'b0;
      miso_out <= 1'b0;
    end else begin
      if (!active) begin
        bit_cnt <= '0;
        if (entry) state <= ACTIVE;
      end else if (!ss_act) begin
        state <= IDLE;
        bit_cnt <= '0;
      end else if (sample) begin
        mosi_sh <= W1'({mosi_sh, s2[1]});
        miso_sh <= W1'({miso_sh, s2[0]});
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
      end
      if (start) sub_act <= sub_pop;
      else if (active & ~ss_act) sub_act <= 1'b0;
      if (sub_pop) sub_sh <= sub_rd_data;
      pres <= start;
      miso_out <= miso_nx;
    end

  // sticky overflow; a new drop wins over a clear
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) cap_overflow <= 1'b0;
    else cap_overflow <= cap_drop | (cap_overflow & ~ovf_clr);

  sync_fifo #(.WIDTH(RW), .DEPTH(CAP_DEPTH)) u_cap (
    .clk(sys_clk), .rst_n(rst_n), .wr_en(complete), .wr_data(cap_wr),
    .rd_en(cap_ready), .rd_data(cap_data), .full(cap_full), .empty(cap_empty)
  );

  sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(SUB_DEPTH)) u_sub (
    .clk(sys_clk), .rst_n(rst_n), .wr_en(sub_wr_valid & ~sub_full), .wr_data(sub_wr_data),
    .rd_en(sub_pop), .rd_data(sub_rd_data), .full(sub_full), .empty(sub_empty)
  );
endmodule

// File: tb/tb_spi_mitm_tap.sv
// tb_spi_mitm_tap: scoreboard bench for a mode-0 tap and a mode-3 active-low tap
module tb_spi_mitm_tap;
  logic clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic ss = 1'b0, sclk = 1'b0, mosi = 1'b0, miso = 1'b0;
  logic sub_en = 1'b0, cap_ready = 1'b1, ovf_clr = 1'b0;
  logic [7:0] sub_wr_data = '0;
  logic [1:0] sub_wr_valid = '0;
  logic [1:0] miso_out, mosi_out, sclk_out, ss_out, sub_wr_ready, cap_valid, cap_overflow;
  logic [16:0] cap_data [2];

  int checks = 0, fails = 0, ci = 0;
  logic cpol = 1'b0, cpha = 1'b0, ssal = 1'b0, fwd_miso = 1'b1, ovf_exp = 1'b0;
  logic [16:0] cap_q [2][$];
  logic [7:0] obs_q [2][$];
  logic [7:0] sub_q [2][$];

  always #5 clk = ~clk;

  spi_mitm_tap u0 (
    .sys_clk(clk), .rst_n(rst_n[0]), .miso_in(miso), .mosi_in(mosi), .sclk_in(sclk), .ss_in(ss),
    .miso_out(miso_out[0]), .mosi_out(mosi_out[0]), .sclk_out(sclk_out[0]), .ss_out(ss_out[0]),
    .sub_en(sub_en), .sub_wr_valid(sub_wr_valid[0]), .sub_wr_ready(sub_wr_ready[0]),
    .sub_wr_data(sub_wr_data), .cap_valid(cap_valid[0]), .cap_ready(cap_ready),
    .cap_data(cap_data[0]), .cap_overflow(cap_overflow[0]), .ovf_clr(ovf_clr)
  );

  spi_mitm_tap #(.CPOL(1), .CPHA(1), .SS_ACTIVE_LOW(1)) u1 (
    .sys_clk(clk), .rst_n(rst_n[1]), .miso_in(miso), .mosi_in(mosi), .sclk_in(sclk), .ss_in(ss),
    .miso_out(miso_out[1]), .mosi_out(mosi_out[1]), .sclk_out(sclk_out[1]), .ss_out(ss_out[1]),
    .sub_en(sub_en), .sub_wr_valid(sub_wr_valid[1]), .sub_wr_ready(sub_wr_ready[1]),
    .sub_wr_data(sub_wr_data), .cap_valid(cap_valid[1]), .cap_ready(cap_ready),
    .cap_data(cap_data[1]), .cap_overflow(cap_overflow[1]), .ovf_clr(ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // a word start consumes one queued substitution word when enabled
  task automatic word_start(output logic s, output logic [7:0] w);
    s = 1'b0;
    w = '0;
    if (sub_en && sub_q[ci].size() > 0) begin
      s = 1'b1;
      w = sub_q[ci].pop_front();
    end
  endtask

  task automatic load(input logic [7:0] d);
    sub_wr_data = d;
    sub_wr_valid[ci] = 1'b1;
    if (sub_q[ci].size() < 4) sub_q[ci].push_back(d);
    cyc(1);
    sub_wr_valid[ci] = 1'b0;
  endtask

  task automatic frame(input logic [7:0] mo, input logic [7:0] mi, input int nbits, input bit close);
    logic s, s2;
    logic [7:0] w, w2;
    word_start(s, w);
    if (nbits == 8) begin
      if (cap_q[ci].size() >= 4) ovf_exp = 1'b1;
      else cap_q[ci].push_back({s, mo, mi});
      obs_q[ci].push_back(s ? w : mi);
    end
    ss = ~ssal;
    cyc(8);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[7-i]; miso = mi[7-i]; cyc(8);
        sclk = ~cpol; cyc(8);
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = mo[7-i]; miso = mi[7-i]; cyc(8);
        sclk = cpol; cyc(8);
      end
    end
    if (nbits == 8) word_start(s2, w2);
    if (close) begin
      cyc(8);
      ss = ssal;
      cyc(16);
    end
  endtask

  // monitor: forwarding delay, reset values, capture scoreboard and observed MISO words
  logic [3:0] h1 = '0, h2 = '0, h3 = '0;
  int ps [2] = '{3, 3};
  int cnt [2] = '{0, 0};
  logic [7:0] obs [2];
  logic pss [2], psclk [2];
  always @(negedge clk) begin
    logic gb, act;
    for (int g = 0; g < 2; g++) begin
      gb = (g == 1);
      if (!rst_n[g]) begin
        check("reset_out", {ss_out[g], sclk_out[g], mosi_out[g], miso_out[g], cap_valid[g],
              sub_wr_ready[g], cap_overflow[g]}, {25'd0, gb, gb, 4'b0001, 1'b0});
        ps[g] = 3; cnt[g] = 0; pss[g] = 1'b0; psclk[g] = sclk_out[g];
      end else begin
        if (ps[g] > 0) ps[g]--;
        else if (fwd_miso) check("fwd4", {ss_out[g], sclk_out[g], mosi_out[g], miso_out[g]}, h3);
        else check("fwd3", {ss_out[g], sclk_out[g], mosi_out[g]}, h3[3:1]);
        if (cap_valid[g] && cap_ready) begin
          if (cap_q[g].size() == 0) begin
            checks++; fails++;
            $display("FAIL cap_unexpected: got %0h expected none", cap_data[g]);
          end else check("cap", cap_data[g], cap_q[g].pop_front());
        end
        act = ss_out[g] ^ gb;
        if (act && sclk_out[g] && !psclk[g]) begin
          obs[g] = {obs[g][6:0], miso_out[g]};
          cnt[g]++;
        end
        if (!act && pss[g]) begin
          if (cnt[g] == 8) begin
            if (obs_q[g].size() == 0) begin
              checks++; fails++;
              $display("FAIL miso_unexpected: got %0h expected none", obs[g]);
            end else check("miso_word", obs[g], obs_q[g].pop_front());
          end
          cnt[g] = 0;
        end
        pss[g] = act;
        psclk[g] = sclk_out[g];
      end
    end
    h3 = h2; h2 = h1; h1 = {ss, sclk, mosi, miso};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(5);
    rst_n[0] = 1'b1;
    cyc(5);
    // plain pass-through frame
    frame(8'he7, 8'h3a, 8, 1);
    // substitution, then pass-through once the queue is empty
    fwd_miso = 1'b0;
    load(8'hc5);
    sub_en = 1'b1;
    frame(8'he7, 8'h3a, 8, 1);
    frame(8'hf1, 8'h29, 8, 1);
    sub_en = 1'b0;
    fwd_miso = 1'b1;
    // capture overflow and clear
    cap_ready = 1'b0;
    for (int k = 0; k < 5; k++) frame(8'($urandom), 8'($urandom), 8, 1);
    cyc(4);
    check("ovf_set", cap_overflow[0], ovf_exp);
    check("cap_held", cap_valid[0], 1'b1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    ovf_exp = 1'b0;
    cyc(1);
    check("ovf_clr", cap_overflow[0], ovf_exp);
    cap_ready = 1'b1;
    cyc(10);
    check("ovf_drain", cap_q[0].size(), 0);
    // partial frame discarded
    frame(8'($urandom), 8'($urandom), 5, 1);
    frame(8'hf1, 8'h29, 8, 1);
    // asynchronous reset in the middle of a word
    frame(8'($urandom), 8'($urandom), 4, 0);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("async_rst", {ss_out[0], sclk_out[0], mosi_out[0], miso_out[0], cap_valid[0],
          sub_wr_ready[0], cap_overflow[0]}, 7'b0000010);
    sub_q[0].delete();
    cyc(3);
    rst_n[0] = 1'b1;
    frame(8'($urandom), 8'($urandom), 3, 1);
    frame(8'h5c, 8'ha3, 8, 1);
    // substitution FIFO full, then random traffic
    fwd_miso = 1'b0;
    for (int k = 0; k < 5; k++) load(8'($urandom));
    check("sub_full", sub_wr_ready[0], 1'b0);
    for (int k = 0; k < 8; k++) begin
      sub_en = 1'($urandom);
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      frame(8'($urandom), 8'($urandom), 8, 1);
    end
    // switch to the CPOL=1, CPHA=1, active-low instance
    rst_n[0] = 1'b0;
    sub_en = 1'b0;
    ci = 1; cpol = 1'b1; cpha = 1'b1; ssal = 1'b1;
    sclk = 1'b1; ss = 1'b1;
    cyc(4);
    rst_n[1] = 1'b1;
    cyc(5);
    load(8'h5a);
    sub_en = 1'b1;
    frame(8'he7, 8'h3a, 8, 1);
    for (int k = 0; k < 6; k++) begin
      sub_en = 1'($urandom);
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      frame(8'($urandom), 8'($urandom), 8, 1);
    end
    for (int k = 0; k < 200 && (cap_q[1].size() > 0 || obs_q[1].size() > 0); k++) cyc(1);
    for (int g = 0; g < 2; g++) begin
      check("cap_left", cap_q[g].size(), 0);
      check("miso_left", obs_q[g].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
